// File: rtl/apb_master_if.sv
// Command/response handshake plus APB completer bus for apb_master.
// Latency: none (wires only).
// Backpressure: CMD_VALID/CMD_READY on commands, RSP_VALID/RSP_READY on responses.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [DATA_WIDTH-1:0] CMD_WDATA;

    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic                  RSP_ERR;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
               PRDATA, PREADY, PSLVERR,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
               PRDATA, PREADY, PSLVERR,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB master: turns one accepted command into one APB transfer and one response.
// Latency: accept at edge n -> PSEL n+1, PENABLE n+2, RSP_VALID n+3 with zero wait states.
// Backpressure: CMD_READY only in IDLE; response held until RSP_READY; ACCESS times out after WAIT_MAX cycles.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_MAX   = 15
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       timeout;

    // PREADY on the final allowed cycle still completes normally.
    assign timeout       = !bus.PREADY && (wait_cnt == 8'(WAIT_MAX - 1));
    assign bus.CMD_READY = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.CMD_VALID) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.PREADY || timeout) state_nxt = RESP;
            RESP:    if (bus.RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= {ADDR_WIDTH{1'b0}};
            bus.PWDATA    <= {DATA_WIDTH{1'b0}};
            bus.RSP_VALID <= 1'b0;
            bus.RSP_ERR   <= 1'b0;
            bus.RSP_RDATA <= {DATA_WIDTH{1'b0}};
        end else begin
            state         <= state_nxt;
            bus.PSEL      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            bus.PENABLE   <= (state_nxt == ACCESS);
            bus.RSP_VALID <= (state_nxt == RESP);

            // The APB address/data registers double as the command latch.
            if (state == IDLE && bus.CMD_VALID) begin
                bus.PWRITE <= bus.CMD_WRITE;
                bus.PADDR  <= bus.CMD_ADDR;
                bus.PWDATA <= bus.CMD_WDATA;
            end

            if (state == SETUP) begin
                wait_cnt <= 8'd0;
            end else if (state == ACCESS && !bus.PREADY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (state == ACCESS && state_nxt == RESP) begin
                bus.RSP_ERR   <= bus.PREADY ? bus.PSLVERR : 1'b1;
                bus.RSP_RDATA <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : {DATA_WIDTH{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, reset-in-ACCESS sequence,
// and randomized transfers compared against a transaction-level reference model.
module tb_apb_master;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int WAIT_MAX = 15;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_MAX(WAIT_MAX)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] prdata;
        int         waits;     // PREADY=0 cycles before the completer answers
        logic       slverr;
        int         stall;     // cycles RSP_READY stays low once RSP_VALID is up
        logic       hold;      // keep CMD_VALID high straight into the next transfer
        int         exp_acc;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] outs();
        return {bus.CMD_READY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA,
                bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA};
    endfunction

    // Transaction-level view: a completer that never answers within WAIT_MAX
    // ACCESS cycles yields an error response with zero data.
    function automatic void ref_model(input vec_t v, output int acc, output int lat,
                                      output logic err, output logic [7:0] rd);
        if (v.waits >= WAIT_MAX) begin
            acc = WAIT_MAX;
            err = 1'b1;
            rd  = 8'h00;
        end else begin
            acc = v.waits + 1;
            err = v.slverr;
            rd  = v.wr ? 8'h00 : v.prdata;
        end
        lat = acc + 2;
    endfunction

    // Called on a negedge with the DUT idle; returns on the negedge after the response handshake.
    task automatic run_xfer(input vec_t v, output int acc, output int lat, output logic err,
                            output logic [7:0] rd, output int proto);
        int cyc;
        int stall_left;
        bit done;
        acc = 0; lat = 0; err = 1'b0; rd = 8'h00; proto = 0; cyc = 0; done = 1'b0;
        stall_left = v.stall;
        if (bus.CMD_READY !== 1'b1) proto++;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = v.wr;
        bus.CMD_ADDR  = v.addr;
        bus.CMD_WDATA = v.wdata;
        bus.PREADY    = 1'($urandom);
        @(negedge PCLK);
        while (!done && cyc < 200) begin
            cyc++;
            // Command-port noise while busy must never be latched.
            bus.CMD_VALID = v.hold ? 1'b1 : 1'($urandom);
            bus.CMD_WRITE = 1'($urandom);
            bus.CMD_ADDR  = 8'($urandom);
            bus.CMD_WDATA = 8'($urandom);
            bus.PREADY    = 1'($urandom);
            bus.PRDATA    = 8'($urandom);
            bus.PSLVERR   = 1'($urandom);
            bus.RSP_READY = 1'($urandom);
            if (bus.CMD_READY !== 1'b0) proto++;
            if (cyc == 1 && !(bus.PSEL === 1'b1 && bus.PENABLE === 1'b0)) proto++;
            if (cyc > 1 && bus.PSEL === 1'b1 && bus.PENABLE !== 1'b1) proto++;
            if (bus.PSEL === 1'b1 &&
                (bus.PADDR !== v.addr || bus.PWDATA !== v.wdata || bus.PWRITE !== v.wr)) proto++;
            if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
                acc++;
                bus.PREADY = (acc == v.waits + 1);
                if (bus.PREADY) begin
                    bus.PRDATA  = v.prdata;
                    bus.PSLVERR = v.slverr;
                end
            end
            if (bus.RSP_VALID === 1'b1) begin
                if (lat == 0) begin
                    lat = cyc;
                    err = bus.RSP_ERR;
                    rd  = bus.RSP_RDATA;
                end
                if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) proto++;
                if (bus.RSP_ERR !== err || bus.RSP_RDATA !== rd) proto++;
                if (stall_left > 0) begin
                    stall_left--;
                    bus.RSP_READY = 1'b0;
                end else begin
                    bus.RSP_READY = 1'b1;
                    bus.CMD_VALID = v.hold;
                    done = 1'b1;
                end
            end
            @(negedge PCLK);
        end
        bus.RSP_READY = 1'b0;
        bus.PREADY    = 1'b0;
        if (!done) begin
            proto++;
            $display("FAIL xfer_timeout: no response after %0d cycles, expected one", cyc);
        end else if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1) begin
            proto++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          acc, lat, racc, rlat, proto, seen;
        logic        err, rerr;
        logic [7:0]  rd, rrd;
        logic [29:0] rst_exp;

        rst_exp = {1'b1, 29'd0};
        bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = 8'h00; bus.CMD_WDATA = 8'h00;
        bus.RSP_READY = 1'b0; bus.PRDATA = 8'h00; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;

        //           wr    addr   wdata  prdata waits slverr stall hold  acc err   rdata
        tbl[0] = '{1'b1, 8'h01, 8'h5A, 8'hEE, 0,   1'b0, 0, 1'b0, 1,  1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'h11, 8'hC3, 3,   1'b0, 0, 1'b0, 4,  1'b0, 8'hC3};
        tbl[2] = '{1'b0, 8'h10, 8'h22, 8'h7E, 200, 1'b0, 1, 1'b0, 15, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 8'h22, 8'h77, 8'h55, 0,   1'b1, 5, 1'b0, 1,  1'b1, 8'h00};
        tbl[4] = '{1'b0, 8'h30, 8'h00, 8'h3C, 14,  1'b0, 0, 1'b0, 15, 1'b0, 8'h3C};
        tbl[5] = '{1'b0, 8'h31, 8'h00, 8'h3D, 15,  1'b0, 0, 1'b0, 15, 1'b1, 8'h00};
        tbl[6] = '{1'b0, 8'h32, 8'h00, 8'h81, 2,   1'b1, 2, 1'b0, 3,  1'b1, 8'h81};
        tbl[7] = '{1'b1, 8'h40, 8'hA5, 8'h00, 1,   1'b0, 0, 1'b1, 2,  1'b0, 8'h00};
        tbl[8] = '{1'b0, 8'h41, 8'h00, 8'h99, 0,   1'b0, 0, 1'b0, 1,  1'b0, 8'h99};

        @(negedge PCLK);
        check("reset_outputs", 32'(outs()), 32'(rst_exp));
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("idle_after_reset", 32'(outs()), 32'(rst_exp));

        for (int i = 0; i < 9; i++) begin
            run_xfer(tbl[i], acc, lat, err, rd, proto);
            check($sformatf("vec%0d_access_cycles", i), 32'(acc), 32'(tbl[i].exp_acc));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_acc + 2));
            check($sformatf("vec%0d_rsp_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_rsp_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
            check($sformatf("vec%0d_protocol_errs", i), 32'(proto), 32'd0);
        end

        // Reset pulse while the completer is stalling in ACCESS.
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b1; bus.CMD_ADDR = 8'h33; bus.CMD_WDATA = 8'h66;
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        bus.CMD_VALID = 1'b0;
        for (int k = 0; k < 10 && bus.PENABLE !== 1'b1; k++) @(negedge PCLK);
        check("rst_reached_access", 32'(bus.PENABLE), 32'd1);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 check("rst_async_outputs", 32'(outs()), 32'(rst_exp));
        bus.PREADY = 1'b1; bus.RSP_READY = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            if (bus.RSP_VALID !== 1'b0 || bus.PSEL !== 1'b0) seen++;
        end
        check("rst_no_response", 32'(seen), 32'd0);
        PRESETn = 1'b1;
        bus.PREADY = 1'b0;
        v = '{1'b0, 8'h07, 8'h00, 8'h5C, 1, 1'b0, 0, 1'b0, 2, 1'b0, 8'h5C};
        run_xfer(v, acc, lat, err, rd, proto);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_rdata", 32'(rd), 32'h5C);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_protocol_errs", 32'(proto), 32'd0);

        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom);
            v.addr   = 8'($urandom);
            v.wdata  = 8'($urandom);
            v.prdata = 8'($urandom);
            v.waits  = $urandom_range(0, 18);
            v.slverr = ($urandom_range(0, 3) == 0);
            v.stall  = $urandom_range(0, 3);
            v.hold   = 1'b0;
            ref_model(v, racc, rlat, rerr, rrd);
            run_xfer(v, acc, lat, err, rd, proto);
            check($sformatf("rnd%0d_access_cycles", i), 32'(acc), 32'(racc));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(rlat));
            check($sformatf("rnd%0d_rsp_err", i), 32'(err), 32'(rerr));
            check($sformatf("rnd%0d_rsp_rdata", i), 32'(rd), 32'(rrd));
            check($sformatf("rnd%0d_protocol_errs", i), 32'(proto), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of CMD_ADDR and PADDR.
REQ-002 Parameter DATA_WIDTH, default 8: width of all data buses.
REQ-003 Parameter WAIT_MAX, default 15: ACCESS-phase cycles allowed before timeout; legal 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 PCLK  input  1  single clock; all state changes on the rising edge.
REQ-006 PRESETn  input  1  asynchronous active-low reset.
REQ-007 CMD_VALID  input  1  command request.
REQ-008 CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY at a PCLK edge.
REQ-009 CMD_WRITE  input  1  1 = write, 0 = read.
REQ-010 CMD_ADDR  input  ADDR_WIDTH  transfer address.
REQ-011 CMD_WDATA  input  DATA_WIDTH  write data.
REQ-012 RSP_VALID  output  1  response available.
REQ-013 RSP_READY  input  1  response consumed when RSP_VALID & RSP_READY at a PCLK edge.
REQ-014 RSP_RDATA  output  DATA_WIDTH  read data (0 for writes and timeouts).
REQ-015 RSP_ERR  output  1  PSLVERR seen or timeout.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-017 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH  APB address and write data.
REQ-018 PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1  APB completer response.

Function
REQ-019 The FSM SHALL have four states, IDLE, SETUP, ACCESS and RESP, and only the transitions listed here.
REQ-020 IDLE: CMD_READY=1, PSEL=0, PENABLE=0; on accept, latch CMD_WRITE/CMD_ADDR/CMD_WDATA into internal registers -> SETUP.
REQ-021 CMD_READY SHALL be 1 only in IDLE; CMD_VALID in any other state is ignored and not latched.
REQ-022 SETUP: exactly one cycle; PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA driven from the latched values -> ACCESS.
REQ-023 ACCESS: PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA held stable from SETUP.
REQ-024 ACCESS: at an edge with PREADY=1 -> RESP; RSP_ERR<=PSLVERR; RSP_RDATA<=PRDATA for reads, 0 for writes.
REQ-025 PRDATA and PSLVERR SHALL be sampled only in ACCESS at an edge where PREADY=1.
REQ-026 Wait counter (8 bit) SHALL be cleared on entering ACCESS and incremented on each ACCESS edge where PREADY=0.
REQ-027 Timeout: at the ACCESS edge where PREADY=0 and the counter equals WAIT_MAX-1 -> RESP with RSP_ERR=1 and RSP_RDATA=0; PREADY=1 on that same edge SHALL win, giving normal completion.
REQ-028 PSEL and PENABLE SHALL be 0 in RESP and IDLE, so a timed-out transfer is dropped on the bus.
REQ-029 RESP: RSP_VALID=1; RSP_RDATA/RSP_ERR held stable until consumed; on RSP_VALID & RSP_READY -> IDLE.
REQ-030 Latency: accept at edge n -> SETUP in cycle n+1, ACCESS n+2; with zero wait states, RSP_VALID=1 in cycle n+3.
REQ-031 Back-to-back throughput: next command accepted no earlier than the cycle after response handshake (minimum 4 cycles per transfer).
REQ-032 PADDR/PWDATA/PWRITE SHALL retain the last transfer's values outside SETUP/ACCESS; they are 0 after reset.
REQ-033 All outputs SHALL be registered, except CMD_READY, which is decoded from state only.

Reset
REQ-034 PRESETn=0 SHALL immediately force: state IDLE, CMD_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0.
REQ-035 Reset asserted mid-transfer, in any state, SHALL abort without producing a response; operation resumes on the first edge after PRESETn rises.

Verification
REQ-036 Write 0x5A to 0x01 with PREADY held 1 -> PSEL rises n+1, PENABLE n+2, PWDATA=0x5A, PADDR=0x01, RSP_VALID n+3, RSP_ERR=0, RSP_RDATA=0.
REQ-037 Read 0x00, PREADY low 3 ACCESS cycles then high with PRDATA=0xC3 -> PENABLE high 4 cycles, RSP_RDATA=0xC3, RSP_ERR=0.
REQ-038 Read with PREADY stuck 0, WAIT_MAX=15 -> exactly 15 ACCESS cycles, then PSEL=0, RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0.
REQ-039 Write with PREADY=1 and PSLVERR=1 -> RSP_ERR=1; RSP_RDATA=0; response held while RSP_READY=0 for 5 cycles.
REQ-040 CMD_VALID held high through two transfers -> second accept only after first response handshake; CMD_READY=0 in SETUP/ACCESS/RESP.
REQ-041 PRESETn pulsed low during ACCESS -> all outputs reset values immediately, no RSP_VALID, next command completes normally.
